addsub_acc_ctrl: RTL
====================

Name: addsub_acc_ctrl

Overview:
- Sequencer that owns one 4-bit signed add/sub unit and drives it as a running accumulator.
- Accepts one operand plus an add/sub command per handshake, then applies acc := acc ± operand over a fixed 3-state sequence.
- Holds per-operation and sticky two's-complement overflow flags, with optional saturation.
- Sits between the switch/button front end and the seven-segment display path; acc, ovf and op_cnt feed the display.

Parameters:
- SAT_EN, 0, 1 = clamp acc to +7/-8 on overflow; 0 = keep the wrapped 4-bit result.
- CNT_W, 4, width of the completed-operation counter op_cnt.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous accumulator clear, same effect as rst on state and outputs.
- in_valid  input  1  operand/command offered this cycle.
- in_data  input  4  signed operand b (two's complement).
- in_sel  input  1  0 = add, 1 = subtract.
- ready  output  1  high only in IDLE; a transfer occurs when in_valid && ready.
- acc  output  4  signed accumulator value.
- ovf  output  1  overflow of the last completed operation.
- ovf_sticky  output  1  OR of ovf since the last rst/clr.
- done  output  1  one-cycle pulse when acc updates.
- drop  output  1  one-cycle pulse when in_valid arrives while ready = 0 (input discarded).
- op_cnt  output  CNT_W  completed operations, wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values (rst or clr): state = IDLE; acc, ovf, ovf_sticky, done, drop = 0; op_cnt = 0; ready = 1 in the following cycle.
- Priority: rst > clr > handshake.
- clr asserted together with in_valid: the input is discarded and drop stays 0.
- clr in EXEC or WB aborts the operation: no done pulse, acc = 0.
- FSM states:
  - IDLE: ready = 1. On in_valid, latch b_r <= in_data and sel_r <= in_sel, then go to EXEC.
  - EXEC: ready = 0. The add/sub unit sees a = acc, b = b_r, sel = sel_r. Its sum and overflow are registered into res_r and ovf_r. Go to WB.
  - WB: ready = 0. Write acc <= res_r (or the saturated value); ovf <= ovf_r; ovf_sticky |= ovf_r; op_cnt <= op_cnt + 1; done = 1. Go to IDLE.
- Latency and throughput:
  - Acceptance in cycle N gives the acc update and done pulse visible at cycle N+2.
  - Maximum rate is one operation per 3 cycles.
- Back-pressure: in_valid during EXEC or WB pulses drop in the same cycle and is otherwise ignored; there is no queue.
- Overflow rule (signed, 4-bit):
  - Add: a[3] == b[3] and sum[3] != a[3].
  - Sub: a[3] != b[3] and sum[3] != a[3].
- Subtract is computed as a + ~b + 1.
- Saturation (SAT_EN = 1, ovf_r = 1): acc <= a[3] ? 4'b1000 : 4'b0111, where a is the acc value used in EXEC. With SAT_EN = 0 the wrapped sum is written.
- ovf holds its value until the next WB, rst or clr; done and drop are single-cycle pulses.
- op_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Operand b = -8 under subtract follows the overflow rule exactly (for example 0 - (-8) overflows).

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE = 2'd0, EXEC = 2'd1, WB = 2'd2.
  - Constants DATA_W = 4, SAT_POS = 4'b0111, SAT_NEG = 4'b1000.
- One sub-module: instantiate the existing 4-bit add/sub unit addsub_4 for the EXEC datapath; its cout output is the overflow flag.
- The FSM, registers and saturation mux stay in addsub_acc_ctrl.

Test Plan:
- Add sequence, SAT_EN = 0: rst, then in_data = 3 add, then in_data = 2 add.
  - Required: acc = 3 then 5; done at accept+2 each; ovf = 0; op_cnt = 2; ready low for exactly 2 cycles after each accept.
- Positive overflow: acc = 5, add 4.
  - SAT_EN = 0: acc = 4'b1001 (-7), ovf = 1, ovf_sticky = 1.
  - SAT_EN = 1: acc = 7, ovf = 1.
  - Then add 0: ovf = 0 while ovf_sticky stays 1.
- Subtract edge cases, SAT_EN = 0:
  - acc = 0 minus -8: result 4'b1000, ovf = 1.
  - acc = -8 minus 1: wrapped result 7, ovf = 1.
  - acc = -3 minus -3: result 0, ovf = 0.
- Back-pressure: hold in_valid high for 7 cycles starting in IDLE.
  - Required: exactly 3 accepts (cycles 0, 3, 6); drop pulses on cycles 1, 2, 4, 5; done pulses on cycles 2 and 5, with the third done on cycle 8.
- Clear mid-operation: accept add 5, assert clr in EXEC.
  - Required: no done; next cycle acc = 0, ovf_sticky = 0, op_cnt = 0, ready = 1.
  - clr together with in_valid in IDLE: no accept, no drop.
- Counter wrap, CNT_W = 4: 17 add-0 operations.
  - Required: op_cnt goes 15 -> 0 -> 1; acc unchanged; rst mid-sequence returns all outputs to reset values on the next edge.

Source files
------------

// File: rtl/addsub_acc_ctrl_pkg.sv
// Shared types and constants for the add/sub accumulator sequencer.
// Holds the FSM encoding, the datapath width and the saturation limits.
package addsub_acc_ctrl_pkg;

    localparam int DATA_W = 4;
    localparam logic [DATA_W-1:0] SAT_POS = 4'b0111;
    localparam logic [DATA_W-1:0] SAT_NEG = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_e;

    // Clamp value chosen by the sign of the operand the overflow came from.
    function automatic logic [DATA_W-1:0] sat_value(input logic neg);
        sat_value = neg ? SAT_NEG : SAT_POS;
    endfunction

endpackage

// File: rtl/addsub_4.sv
// 4-bit signed add/subtract unit; subtract is a + ~b + 1.
// cout reports two's-complement overflow, not the raw carry.
module addsub_4
    import addsub_acc_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W-1:0] b_eff_s;

    // Operand inversion, sum and signed overflow detection.
    always_comb begin
        b_eff_s = sel ? ~b : b;
        sum     = a + b_eff_s + {3'b000, sel};
        cout    = (a[DATA_W-1] == b_eff_s[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
    end

endmodule

// File: rtl/addsub_acc_ctrl.sv
// Three-state sequencer driving addsub_4 as a running accumulator:
// IDLE accepts an operand, EXEC registers the unit result, WB commits it.
module addsub_acc_ctrl
    import addsub_acc_ctrl_pkg::*;
#(
    parameter bit SAT_EN = 1'b0,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              ready,
    output logic [DATA_W-1:0] acc,
    output logic              ovf,
    output logic              ovf_sticky,
    output logic              done,
    output logic              drop,
    output logic [CNT_W-1:0]  op_cnt
);

    state_e            state_r;
    state_e            state_s;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] res_r;
    logic              sel_r;
    logic              ovf_r;
    logic              ovf_last_r;
    logic              ovf_sticky_r;
    logic              ready_r;
    logic [CNT_W-1:0]  op_cnt_r;
    logic [DATA_W-1:0] sum_s;
    logic              unit_ovf_s;
    logic              accept_s;
    logic [DATA_W-1:0] wb_val_s;

    addsub_4 u_addsub (
        .a    (acc_r),
        .b    (b_r),
        .sel  (sel_r),
        .sum  (sum_s),
        .cout (unit_ovf_s)
    );

    // State register; rst and clr both return to IDLE.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode and handshake qualification.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    accept_s = 1'b1;
                    state_s  = EXEC;
                end else begin
                    state_s  = IDLE;
                end
            end
            EXEC:    state_s = WB;
            WB:      state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Writeback value: clamp toward the sign of the pre-operation acc on overflow.
    always_comb begin
        if (SAT_EN && ovf_r) begin
            wb_val_s = sat_value(acc_r[DATA_W-1]);
        end else begin
            wb_val_s = res_r;
        end
    end

    // Operand latch, EXEC result capture and WB commit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_r        <= '0;
            b_r          <= '0;
            res_r        <= '0;
            sel_r        <= 1'b0;
            ovf_r        <= 1'b0;
            ovf_last_r   <= 1'b0;
            ovf_sticky_r <= 1'b0;
            ready_r      <= 1'b1;
            op_cnt_r     <= '0;
        end else begin
            ready_r <= (state_s == IDLE);
            if (accept_s) begin
                b_r   <= in_data;
                sel_r <= in_sel;
            end
            if (state_r == EXEC) begin
                res_r <= sum_s;
                ovf_r <= unit_ovf_s;
            end
            if (state_r == WB) begin
                acc_r        <= wb_val_s;
                ovf_last_r   <= ovf_r;
                ovf_sticky_r <= ovf_sticky_r | ovf_r;
                op_cnt_r     <= op_cnt_r + CNT_W'(1);
            end
        end
    end

    // Pulses are gated by rst/clr so an aborted WB never reports completion.
    assign done       = (state_r == WB) && !rst && !clr;
    assign drop       = in_valid && !ready_r && !rst && !clr;
    assign ready      = ready_r;
    assign acc        = acc_r;
    assign ovf        = ovf_last_r;
    assign ovf_sticky = ovf_sticky_r;
    assign op_cnt     = op_cnt_r;

endmodule
